// File: rtl/dcs_out_quant.sv
// dcs_out_quant: double-banked capture of 8-word result bursts from the
// attention core, followed by per-frame requantization to unsigned 8-bit.
//
// Output handshake: a byte transfers on a rising clk edge where
// q_valid && q_ready. Once q_valid is high it stays high, and q_data,
// q_last, q_shift and q_idx stay stable, until that transfer happens.
// q_valid never depends combinationally on q_ready.
// The input side has no ready: every in_valid word is consumed.
module dcs_out_quant (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        q_valid,
  input  logic        q_ready,
  output logic [7:0]  q_data,
  output logic        q_last,
  output logic [4:0]  q_shift,
  output logic [2:0]  q_idx,
  output logic        drop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t state, state_nx;

  // Two frame banks plus their captured max / argmax.
  logic [31:0] mem  [2][8];
  logic [31:0] bmax [2];
  logic [2:0]  bidx [2];
  logic [1:0]  full;

  // Capture side.
  logic        wptr;
  logic [2:0]  wcnt;
  logic        frm_drop;
  logic [31:0] run_max;
  logic [2:0]  run_idx;

  // Output side.
  logic        rptr;
  logic [2:0]  rk;
  logic [4:0]  shift_r;
  logic [2:0]  idx_r;

  logic        fire;
  logic        release_now;
  logic        slot0;
  logic        accept0;
  logic        cur_drop;
  logic        wr_en;
  logic        frame_done;
  logic        new_is_max;
  logic [31:0] max_nx;
  logic [2:0]  idx_nx;
  logic [4:0]  calc_s;
  logic [7:0]  byte0;
  logic [7:0]  byte_nx;

  // Shift that brings the frame max into 8 bits: max(0, bitlen(m) - 8).
  function automatic logic [4:0] calc_shift(input logic [31:0] m);
    logic [5:0] bl;
    bl = 6'd0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) bl = 6'(i + 1);
    end
    calc_shift = (bl > 6'd8) ? 5'(bl - 6'd8) : 5'd0;
  endfunction

  // Round-half-up right shift with saturation to 255, in 33-bit arithmetic.
  function automatic logic [7:0] quant(input logic [31:0] w, input logic [4:0] s);
    logic [32:0] rnd;
    logic [32:0] sum;
    logic [32:0] shf;
    rnd   = (s == 5'd0) ? 33'd0 : (33'd1 << (s - 5'd1));
    sum   = {1'b0, w} + rnd;
    shf   = sum >> s;
    quant = (shf > 33'd255) ? 8'hFF : shf[7:0];
  endfunction

  assign fire        = q_valid & q_ready;
  assign release_now = fire & (rk == 3'd7);
  assign slot0       = (wcnt == 3'd0);
  // A bank that is handing over its last byte this cycle counts as free.
  assign accept0     = !full[wptr] || (release_now && (rptr == wptr));
  assign cur_drop    = slot0 ? !accept0 : frm_drop;
  assign wr_en       = in_valid & !cur_drop;
  assign frame_done  = in_valid & (wcnt == 3'd7);
  assign new_is_max  = slot0 || (in_data > run_max);
  assign max_nx      = new_is_max ? in_data : run_max;
  assign idx_nx      = new_is_max ? wcnt : run_idx;

  assign calc_s  = calc_shift(bmax[rptr]);
  assign byte0   = quant(mem[rptr][0], calc_s);
  assign byte_nx = quant(mem[rptr][rk + 3'd1], shift_r);

  assign q_shift = shift_r;
  assign q_idx   = idx_r;

  // Capture control: slot counter, running max, bank full flags, drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= 3'd0;
      wptr     <= 1'b0;
      frm_drop <= 1'b0;
      run_max  <= 32'd0;
      run_idx  <= 3'd0;
      drop     <= 1'b0;
      full     <= 2'b00;
    end else begin
      drop <= frame_done & cur_drop;
      if (release_now) full[rptr] <= 1'b0;
      if (frame_done && !cur_drop) full[wptr] <= 1'b1;
      if (in_valid) begin
        wcnt     <= wcnt + 3'd1;
        frm_drop <= cur_drop;
        run_max  <= max_nx;
        run_idx  <= idx_nx;
        // A dropped frame leaves wptr alone so banks stay in arrival order.
        if (frame_done && !cur_drop) wptr <= ~wptr;
      end
    end
  end

  // Bank storage: words of accepted frames and the frame max / argmax.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr][wcnt] <= in_data;
    if (frame_done && !cur_drop) begin
      bmax[wptr] <= max_nx;
      bidx[wptr] <= idx_nx;
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Output FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (full[rptr]) state_nx = S_CALC;
      S_CALC: state_nx = S_SEND;
      S_SEND: if (release_now) state_nx = full[~rptr] ? S_CALC : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output datapath: frame shift/idx latch, byte index and registered byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr    <= 1'b0;
      rk      <= 3'd0;
      shift_r <= 5'd0;
      idx_r   <= 3'd0;
      q_valid <= 1'b0;
      q_data  <= 8'd0;
      q_last  <= 1'b0;
    end else begin
      case (state)
        S_CALC: begin
          shift_r <= calc_s;
          idx_r   <= bidx[rptr];
          q_data  <= byte0;
          q_valid <= 1'b1;
          q_last  <= 1'b0;
          rk      <= 3'd0;
        end
        S_SEND: begin
          if (fire) begin
            if (rk == 3'd7) begin
              q_valid <= 1'b0;
              q_last  <= 1'b0;
              rptr    <= ~rptr;
            end else begin
              rk      <= rk + 3'd1;
              q_data  <= byte_nx;
              q_last  <= (rk == 3'd6);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcs_out_quant.sv
// Testbench for dcs_out_quant: table of hand-computed frames, hand-written
// backpressure / same-cycle-release / reset sequences, and a randomized
// phase checked by a frame-level reference model with an expected queue.
module tb_dcs_out_quant;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        q_ready = 1'b0;
  logic        q_valid;
  logic [7:0]  q_data;
  logic        q_last;
  logic [4:0]  q_shift;
  logic [2:0]  q_idx;
  logic        drop;

  always #5 clk = ~clk;

  dcs_out_quant dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .q_data   (q_data),
    .q_last   (q_last),
    .q_shift  (q_shift),
    .q_idx    (q_idx),
    .drop     (drop)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic int bitlen(input longint unsigned x);
    int n;
    n = 0;
    while (x != 0) begin
      x = x >> 1;
      n++;
    end
    return n;
  endfunction

  function automatic logic [4:0] ref_shift(input logic [31:0] m);
    int bl;
    bl = bitlen(longint'(m));
    return (bl > 8) ? 5'(bl - 8) : 5'd0;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] w, input logic [4:0] s);
    longint unsigned v;
    v = longint'(w);
    if (s != 0) v = v + (64'd1 << (s - 1));
    v = v >> s;
    return (v > 255) ? 8'd255 : v[7:0];
  endfunction

  task automatic ref_frame(input logic [31:0] w[8], output logic [7:0] eb[8],
                           output logic [4:0] es, output logic [2:0] ei);
    logic [31:0] m;
    m = w[0];
    ei = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (w[i] > m) begin
        m = w[i];
        ei = 3'(i);
      end
    end
    es = ref_shift(m);
    for (int i = 0; i < 8; i++) eb[i] = ref_byte(w[i], es);
  endtask

  // ---------------- scoreboard / model ----------------
  // Entry layout: {last, shift, idx, data}.
  logic [16:0] exp_q[$];
  int          m_wcnt = 0;
  int          m_rcnt = 0;
  int          m_stored = 0;
  bit          m_acc = 1'b0;
  bit          m_coincide = 1'b0;
  bit          exp_drop = 1'b0;
  bit          hold_pend = 1'b0;
  logic [16:0] hold_val;
  logic [31:0] m_words[8];
  int          drop_cnt = 0;

  // Model: predicts, at each falling edge, what the next rising edge does.
  always @(negedge clk) begin : model
    logic        rel;
    logic [7:0]  eb[8];
    logic [4:0]  es;
    logic [2:0]  ei;
    logic [16:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_wcnt    = 0;
      m_rcnt    = 0;
      m_stored  = 0;
      exp_drop  = 1'b0;
      hold_pend = 1'b0;
      check("reset_outputs_zero", {q_valid, q_data, q_last, q_shift, q_idx, drop}, 64'd0);
    end else begin
      check("drop_timing", drop, exp_drop);
      exp_drop = 1'b0;
      if (drop) drop_cnt++;
      if (hold_pend) check("hold_stable", {q_valid, q_data, q_last, q_shift, q_idx}, {1'b1, hold_val});
      hold_pend = q_valid && !q_ready;
      hold_val  = {q_data, q_last, q_shift, q_idx};
      rel = 1'b0;
      if (q_valid && q_ready) begin
        check("byte_was_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("byte_vs_model", {q_last, q_shift, q_idx, q_data}, e);
        end
        rel = (m_rcnt == 7);
        m_rcnt = (m_rcnt + 1) % 8;
      end
      if (in_valid) begin
        if (m_wcnt == 0) begin
          m_acc = (m_stored - (rel ? 1 : 0)) < 2;
          if (rel && m_stored == 2) m_coincide = 1'b1;
        end
        m_words[m_wcnt] = in_data;
        if (m_wcnt == 7) begin
          if (m_acc) begin
            ref_frame(m_words, eb, es, ei);
            for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, es, ei, eb[i]});
            m_stored++;
          end else begin
            exp_drop = 1'b1;
          end
        end
        m_wcnt = (m_wcnt + 1) % 8;
      end
      if (rel) m_stored--;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_word(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w[8]);
    for (int i = 0; i < 8; i++) drive_word(w[i]);
  endtask

  task automatic get_byte(output logic [7:0] d, output logic l, output logic [4:0] s,
                          output logic [2:0] ix, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    d = 8'd0; l = 1'b0; s = 5'd0; ix = 3'd0;
    while (!ok && n < 400) begin
      @(negedge clk);
      n++;
      if (q_valid === 1'b1 && q_ready === 1'b1) begin
        ok = 1'b1;
        d = q_data; l = q_last; s = q_shift; ix = q_idx;
      end
    end
  endtask

  task automatic collect_frame(output logic [7:0] gb[8], output logic [4:0] gs,
                               output logic [2:0] gi, output logic [7:0] glast,
                               output bit gstable, output int lat, output bit ok);
    logic [7:0] d;
    logic       l;
    logic [4:0] s;
    logic [2:0] ix;
    int         n;
    bit         okb;
    ok = 1'b1; gstable = 1'b1; glast = 8'd0; lat = 0; gs = 5'd0; gi = 3'd0;
    for (int k = 0; k < 8; k++) gb[k] = 8'd0;
    for (int k = 0; k < 8; k++) begin
      get_byte(d, l, s, ix, n, okb);
      if (!okb) begin
        ok = 1'b0;
        break;
      end
      gb[k] = d;
      glast[k] = l;
      if (k == 0) begin
        gs = s; gi = ix; lat = n;
      end else if (s !== gs || ix !== gi) begin
        gstable = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] eb[8], input logic [4:0] es,
                             input logic [2:0] ei, input logic [7:0] gb[8], input logic [4:0] gs,
                             input logic [2:0] gi, input logic [7:0] glast, input bit gstable);
    check({tag, "_shift"}, gs, es);
    check({tag, "_idx"}, gi, ei);
    for (int i = 0; i < 8; i++) check($sformatf("%s_byte%0d", tag, i), gb[i], eb[i]);
    check({tag, "_last_pos"}, glast, 8'h80);
    check({tag, "_tag_stable"}, gstable, 1);
  endtask

  // Fetch a frame from the DUT and compare it with the reference arithmetic.
  task automatic expect_frame(input string tag, input logic [31:0] w[8], output int lat);
    logic [7:0] eb[8], gb[8];
    logic [4:0] es, gs;
    logic [2:0] ei, gi;
    logic [7:0] glast;
    bit         gstable, ok;
    ref_frame(w, eb, es, ei);
    collect_frame(gb, gs, gi, glast, gstable, lat, ok);
    check({tag, "_arrived"}, ok, 1);
    check_frame(tag, eb, es, ei, gb, gs, gi, glast, gstable);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0][31:0] w;
    logic [4:0]       sh;
    logic [2:0]       id;
    logic [7:0][7:0]  b;
  } vec_t;

  localparam int NVEC = 8;
  vec_t tbl[NVEC];

  task automatic set_w(input int v, input logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7);
    tbl[v].w[0] = w0; tbl[v].w[1] = w1; tbl[v].w[2] = w2; tbl[v].w[3] = w3;
    tbl[v].w[4] = w4; tbl[v].w[5] = w5; tbl[v].w[6] = w6; tbl[v].w[7] = w7;
  endtask

  task automatic set_b(input int v, input logic [4:0] sh, input logic [2:0] id,
                       input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    tbl[v].sh = sh; tbl[v].id = id;
    tbl[v].b[0] = b0; tbl[v].b[1] = b1; tbl[v].b[2] = b2; tbl[v].b[3] = b3;
    tbl[v].b[4] = b4; tbl[v].b[5] = b5; tbl[v].b[6] = b6; tbl[v].b[7] = b7;
  endtask

  bit drv_done = 1'b0;

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] wa[8], wb[8], wc[8], wd[8];
    logic [7:0]  eb[8], gb[8];
    logic [4:0]  gs;
    logic [2:0]  gi;
    logic [7:0]  glast;
    logic [7:0]  d;
    logic        l;
    logic [4:0]  s;
    logic [2:0]  ix;
    bit          gstable, ok;
    int          lat, n, d0, vseen;

    // Ramp, rounding, saturation, zeros, full-scale, ties, odd max, s=0 edge.
    set_w(0, 10, 20, 30, 40, 50, 60, 70, 80);
    set_b(0, 0, 7, 10, 20, 30, 40, 50, 60, 70, 80);
    set_w(1, 1000, 1000, 1000, 70000, 1000, 1000, 1000, 1000);
    set_b(1, 9, 3, 2, 2, 2, 137, 2, 2, 2, 2);
    set_w(2, 511, 511, 511, 511, 511, 511, 511, 511);
    set_b(2, 1, 0, 255, 255, 255, 255, 255, 255, 255, 255);
    set_w(3, 0, 0, 0, 0, 0, 0, 0, 0);
    set_b(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_w(4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    set_b(4, 24, 0, 255, 255, 255, 255, 255, 255, 255, 255);
    set_w(5, 5, 300, 700, 2, 700, 255, 256, 699);
    set_b(5, 2, 2, 1, 75, 175, 1, 175, 64, 64, 175);
    set_w(6, 1, 2, 3, 255, 254, 256, 0, 128);
    set_b(6, 1, 5, 1, 1, 2, 128, 127, 128, 0, 64);
    set_w(7, 255, 0, 17, 200, 255, 1, 2, 3);
    set_b(7, 0, 0, 255, 0, 17, 200, 255, 1, 2, 3);

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_q_valid", q_valid, 0);
    check("reset_q_data", q_data, 0);
    check("reset_q_last", q_last, 0);
    check("reset_q_shift", q_shift, 0);
    check("reset_q_idx", q_idx, 0);
    check("reset_drop", drop, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven frames with q_ready held high.
    q_ready = 1'b1;
    for (int v = 0; v < NVEC; v++) begin
      for (int i = 0; i < 8; i++) begin
        wa[i] = tbl[v].w[i];
        eb[i] = tbl[v].b[i];
      end
      send_frame(wa);
      collect_frame(gb, gs, gi, glast, gstable, lat, ok);
      check($sformatf("vec%0d_arrived", v), ok, 1);
      check($sformatf("vec%0d_latency", v), lat, 3);
      check_frame($sformatf("vec%0d", v), eb, tbl[v].sh, tbl[v].id, gb, gs, gi, glast, gstable);
      @(posedge clk);
      #1;
    end

    // Backpressure: A, B, C back-to-back with q_ready low; C is dropped.
    q_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wa[i] = $urandom_range(0, 32'h0000FFFF);
      wb[i] = $urandom() >> $urandom_range(0, 31);
      wc[i] = $urandom();
    end
    d0 = drop_cnt;
    send_frame(wa);
    send_frame(wb);
    send_frame(wc);
    @(negedge clk);
    check("bp_drop_on_C_last_word", drop, 1);
    repeat (4) @(posedge clk);
    #1;
    check("bp_drop_count", drop_cnt - d0, 1);
    check("bp_holding_A", q_valid, 1);
    q_ready = 1'b1;
    expect_frame("bp_A", wa, lat);
    expect_frame("bp_B", wb, lat);
    check("bp_B_one_bubble", lat, 2);
    vseen = 0;
    repeat (20) begin
      @(negedge clk);
      if (q_valid) vseen++;
    end
    check("bp_C_never_output", vseen, 0);

    // Same-cycle release: A's last byte handshakes as D's slot-0 arrives.
    @(posedge clk);
    #1;
    q_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wa[i] = $urandom() >> $urandom_range(0, 31);
      wb[i] = $urandom() >> $urandom_range(0, 31);
      wd[i] = $urandom() >> $urandom_range(0, 31);
    end
    send_frame(wa);
    send_frame(wb);
    repeat (4) @(posedge clk);
    #1;
    m_coincide = 1'b0;
    d0 = drop_cnt;
    q_ready = 1'b1;
    fork
      begin
        repeat (7) @(posedge clk);
        #1;
        send_frame(wd);
      end
      begin
        expect_frame("scr_A", wa, lat);
        expect_frame("scr_B", wb, lat);
        expect_frame("scr_D", wd, lat);
      end
    join
    check("scr_coincidence_hit", m_coincide, 1);
    check("scr_no_drop", drop_cnt - d0, 0);

    // Reset mid-SEND, with a partial input frame in flight.
    @(posedge clk);
    #1;
    q_ready = 1'b0;
    for (int i = 0; i < 8; i++) wa[i] = $urandom();
    send_frame(wa);
    for (int i = 0; i < 3; i++) drive_word($urandom());
    q_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      get_byte(d, l, s, ix, n, ok);
      check($sformatf("rst_pre_byte%0d_arrived", k), ok, 1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_q_valid", q_valid, 0);
    check("rst_mid_outputs", {q_data, q_last, q_shift, q_idx, drop}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) wb[i] = 32'(i * 4000 + 123);
    send_frame(wb);
    expect_frame("rst_fresh", wb, lat);
    check("rst_fresh_latency", lat, 3);
    @(posedge clk);
    #1;

    // Randomized traffic with random q_ready, checked by the model.
    drv_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 7) == 0) begin
              @(posedge clk);
              #1;
            end
            case ($urandom_range(0, 9))
              0:       drive_word(32'd0);
              1:       drive_word(32'hFFFFFFFF);
              default: drive_word($urandom() >> $urandom_range(0, 31));
            endcase
          end
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1;
          q_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    q_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rand_drain_empty", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("rand_idle_after_drain", q_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Run-time bound.
  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
